zeroriscy_register_file_mp: RTL and testbench

- Flip-flop register file with parametrised read-port count, write-port count and width, plus an RV32E mode.
- Adds optional write-to-read bypass.
- Adds a per-register pending scoreboard so long-latency units (posit/PPU, mul/div) can reserve a destination at issue and write it back later.
- Sits in the ID stage: read ports feed operands, write ports come from the EX/late-writeback paths, and busy flags feed the hazard/stall logic.

---
 rtl/zeroriscy_register_file_mp.sv | 110 +++++++++++
 tb/tb_zeroriscy_register_file_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_register_file_mp.sv
// Multi-port flip-flop register file with optional write-to-read bypass and a
// per-register pending scoreboard for long-latency producers (PPU, mul/div).
module zeroriscy_register_file_mp #(
    parameter int unsigned RV32E      = 0,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RPORTS = 3,
    parameter int unsigned NUM_WPORTS = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [5*NUM_RPORTS-1:0]          raddr_i,
    output logic [DATA_WIDTH*NUM_RPORTS-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [5*NUM_WPORTS-1:0]          waddr_i,
    input  logic [DATA_WIDTH*NUM_WPORTS-1:0] wdata_i,
    input  logic [NUM_WPORTS-1:0]            we_i,
    input  logic                             resv_valid_i,
    input  logic [4:0]                       resv_addr_i,
    output logic                             any_pending_o,
    output logic [5:0]                       pending_cnt_o
);

    localparam int unsigned ADDR_WIDTH = (RV32E != 0) ? 4 : 5;
    localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int unsigned LATE       = NUM_WPORTS - 1;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [NUM_REGS-1:0]                 pend_q;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] wdat;
    logic [NUM_REGS-1:0]                 wen;
    logic [NUM_REGS-1:0]                 set_v;
    logic [NUM_REGS-1:0]                 clr_v;
    logic [NUM_REGS-1:0]                 pend_d;
    logic                                inc;
    logic                                dec;
    logic [5:0]                          cnt_d;

    function automatic logic addr_ok(input logic [4:0] a);
        addr_ok = (a != 5'd0) && ((RV32E == 0) || !a[4]);
    endfunction

    // Per-register decode; starting at r=1 and stopping at NUM_REGS drops x0
    // and out-of-range RV32E addresses without a separate validity check.
    always_comb begin
        wdat  = '0;
        wen   = '0;
        set_v = '0;
        clr_v = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p] && waddr_i[p*5 +: 5] == 5'(r)) begin
                    wen[r]  = 1'b1;
                    wdat[r] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            set_v[r] = resv_valid_i && (resv_addr_i == 5'(r));
            clr_v[r] = we_i[LATE] && (waddr_i[LATE*5 +: 5] == 5'(r));
        end
        pend_d = (pend_q & ~clr_v) | set_v;
        inc    = |(set_v & ~pend_q);
        dec    = |(clr_v & pend_q & ~set_v);
        cnt_d  = pending_cnt_o + 6'(inc) - 6'(dec);
    end

    always_comb begin
        logic [4:0]            ra;
        logic [ADDR_WIDTH-1:0] idx;
        rdata_o = '0;
        rbusy_o = '0;
        ra      = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_RPORTS; k++) begin
            ra  = raddr_i[k*5 +: 5];
            idx = ra[ADDR_WIDTH-1:0];
            if (addr_ok(ra)) begin
                rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[idx];
                rbusy_o[k]                          = pend_q[idx];
                if (BYPASS != 0) begin
                    if (wen[idx]) begin
                        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdat[idx];
                    end
                    if (clr_v[idx] && !set_v[idx]) begin
                        rbusy_o[k] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q         <= '0;
            pend_q        <= '0;
            pending_cnt_o <= '0;
            any_pending_o <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (wen[r]) begin
                    mem_q[r] <= wdat[r];
                end
            end
            pend_q        <= pend_d;
            pending_cnt_o <= cnt_d;
            any_pending_o <= (cnt_d != 6'd0);
        end
    end

endmodule

// File: tb/tb_zeroriscy_register_file_mp.sv
// Scoreboard bench: three instances (default, no-bypass, RV32E) driven by
// directed cycles; expectations are queued with the stimulus and drained.
module tb_zeroriscy_register_file_mp;

    localparam int S_MD = 0, S_MB = 3, S_MCNT = 6, S_MANY = 7;
    localparam int S_BD = 8, S_BB = 9, S_BCNT = 10;
    localparam int S_ED = 11, S_EB = 12, S_ECNT = 13, S_EANY = 14;

    logic clk, rst;

    logic [14:0] m_raddr;  logic [95:0] m_rdata;  logic [2:0] m_rbusy;
    logic [9:0]  m_waddr;  logic [63:0] m_wdata;  logic [1:0] m_we;
    logic m_rv;  logic [4:0] m_ra;  logic m_any;  logic [5:0] m_cnt;

    logic [4:0]  b_raddr;  logic [31:0] b_rdata;  logic b_rbusy;
    logic [9:0]  b_waddr;  logic [63:0] b_wdata;  logic [1:0] b_we;
    logic b_rv;  logic [4:0] b_ra;  logic b_any;  logic [5:0] b_cnt;

    logic [4:0]  e_raddr;  logic [31:0] e_rdata;  logic e_rbusy;
    logic [9:0]  e_waddr;  logic [63:0] e_wdata;  logic [1:0] e_we;
    logic e_rv;  logic [4:0] e_ra;  logic e_any;  logic [5:0] e_cnt;

    zeroriscy_register_file_mp u_dut (
        .clk(clk), .rst(rst), .raddr_i(m_raddr), .rdata_o(m_rdata), .rbusy_o(m_rbusy),
        .waddr_i(m_waddr), .wdata_i(m_wdata), .we_i(m_we), .resv_valid_i(m_rv),
        .resv_addr_i(m_ra), .any_pending_o(m_any), .pending_cnt_o(m_cnt)
    );

    zeroriscy_register_file_mp #(.NUM_RPORTS(1), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .raddr_i(b_raddr), .rdata_o(b_rdata), .rbusy_o(b_rbusy),
        .waddr_i(b_waddr), .wdata_i(b_wdata), .we_i(b_we), .resv_valid_i(b_rv),
        .resv_addr_i(b_ra), .any_pending_o(b_any), .pending_cnt_o(b_cnt)
    );

    zeroriscy_register_file_mp #(.RV32E(1), .NUM_RPORTS(1)) u_e (
        .clk(clk), .rst(rst), .raddr_i(e_raddr), .rdata_o(e_rdata), .rbusy_o(e_rbusy),
        .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we), .resv_valid_i(e_rv),
        .resv_addr_i(e_ra), .any_pending_o(e_any), .pending_cnt_o(e_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] sample(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            0, 1, 2: v = m_rdata[(sel - S_MD)*32 +: 32];
            3, 4, 5: v = 32'(m_rbusy[sel - S_MB]);
            S_MCNT:  v = 32'(m_cnt);
            S_MANY:  v = 32'(m_any);
            S_BD:    v = b_rdata;
            S_BB:    v = 32'(b_rbusy);
            S_BCNT:  v = 32'(b_cnt);
            S_ED:    v = e_rdata;
            S_EB:    v = 32'(e_rbusy);
            S_ECNT:  v = 32'(e_cnt);
            S_EANY:  v = 32'(e_any);
            default: v = 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_q.push_back('{tag, sel, val});
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, sample(e.sel), e.val);
        end
    endtask

    task automatic idle();
        m_we = '0; m_rv = 1'b0; m_ra = '0;
        b_we = '0; b_rv = 1'b0; b_ra = '0;
        e_we = '0; e_rv = 1'b0; e_ra = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mwrite(input int p, input logic [4:0] a, input logic [31:0] d);
        m_we[p] = 1'b1; m_waddr[p*5 +: 5] = a; m_wdata[p*32 +: 32] = d;
    endtask
    task automatic bwrite(input int p, input logic [4:0] a, input logic [31:0] d);
        b_we[p] = 1'b1; b_waddr[p*5 +: 5] = a; b_wdata[p*32 +: 32] = d;
    endtask
    task automatic ewrite(input int p, input logic [4:0] a, input logic [31:0] d);
        e_we[p] = 1'b1; e_waddr[p*5 +: 5] = a; e_wdata[p*32 +: 32] = d;
    endtask
    task automatic mread(input int k, input logic [4:0] a);
        m_raddr[k*5 +: 5] = a;
    endtask
    task automatic mresv(input logic [4:0] a);
        m_rv = 1'b1; m_ra = a;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        m_raddr = '0; m_waddr = '0; m_wdata = '0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0;
        e_raddr = '0; e_waddr = '0; e_wdata = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push("rst_data", S_MD, 0); push("rst_busy", S_MB, 0);
        push("rst_cnt", S_MCNT, 0); push("rst_any", S_MANY, 0);
        push("rst_bcnt", S_BCNT, 0); push("rst_ecnt", S_ECNT, 0);
        drain();
        rst = 1'b0;

        // two pending registers, then an asynchronous reset pulse mid-cycle
        mread(0, 2); mwrite(0, 2, 32'hA5A5_A5A5); mresv(2);
        push("pre_byp", S_MD, 32'hA5A5_A5A5); push("pre_busy_now", S_MB, 0);
        drain();
        tick();
        mresv(4);
        tick();
        push("pre_data", S_MD, 32'hA5A5_A5A5); push("pre_busy", S_MB, 1);
        push("pre_cnt", S_MCNT, 2); push("pre_any", S_MANY, 1);
        drain();
        #1 rst = 1'b1;
        push("arst_data", S_MD, 0); push("arst_busy", S_MB, 0);
        push("arst_cnt", S_MCNT, 0); push("arst_any", S_MANY, 0);
        drain();
        rst = 1'b0;
        tick();
        push("post_rst_cnt", S_MCNT, 0); push("post_rst_busy", S_MB, 0);
        drain();

        mread(0, 0); mwrite(1, 0, 32'hDEAD_BEEF);
        push("x0_now", S_MD, 0);
        drain();
        tick();
        push("x0_after", S_MD, 0);
        drain();

        mread(1, 5); mwrite(0, 5, 32'h1111_1111); mwrite(1, 5, 32'h2222_2222);
        b_raddr = 5'd5; bwrite(0, 5, 32'h1111_1111); bwrite(1, 5, 32'h2222_2222);
        push("prio_byp_now", S_MD + 1, 32'h2222_2222); push("prio_nobyp_now", S_BD, 0);
        drain();
        tick();
        push("prio_after", S_MD + 1, 32'h2222_2222); push("prio_nobyp_after", S_BD, 32'h2222_2222);
        push("late_nonpend_cnt", S_MCNT, 0);
        drain();

        mread(2, 7); mresv(7);
        b_raddr = 5'd7; b_rv = 1'b1; b_ra = 5'd7;
        push("resv_busy_now", S_MB + 2, 0);
        drain();
        tick();
        push("resv_busy", S_MB + 2, 1); push("resv_cnt", S_MCNT, 1); push("resv_any", S_MANY, 1);
        push("b_resv_busy", S_BB, 1); push("b_resv_cnt", S_BCNT, 1);
        drain();
        mwrite(0, 7, 32'h0000_1234);
        push("p0_busy_now", S_MB + 2, 1); push("p0_data_now", S_MD + 2, 32'h0000_1234);
        drain();
        tick();
        push("p0_busy", S_MB + 2, 1); push("p0_cnt", S_MCNT, 1); push("p0_data", S_MD + 2, 32'h0000_1234);
        drain();
        mwrite(1, 7, 32'h0000_CAFE); bwrite(1, 7, 32'h0000_CAFE);
        push("late_mask_now", S_MB + 2, 0); push("late_data_now", S_MD + 2, 32'h0000_CAFE);
        push("b_late_nomask", S_BB, 1); push("b_late_old", S_BD, 0);
        drain();
        tick();
        push("late_busy", S_MB + 2, 0); push("late_cnt", S_MCNT, 0); push("late_any", S_MANY, 0);
        push("late_data", S_MD + 2, 32'h0000_CAFE);
        push("b_late_busy", S_BB, 0); push("b_late_cnt", S_BCNT, 0); push("b_late_data", S_BD, 32'h0000_CAFE);
        drain();

        mread(0, 9); mresv(9);
        tick();
        push("x9_busy", S_MB, 1); push("x9_cnt", S_MCNT, 1);
        drain();
        mresv(9); mwrite(1, 9, 32'h0000_0099);
        push("coll_busy_now", S_MB, 1); push("coll_data_now", S_MD, 32'h0000_0099);
        drain();
        tick();
        push("coll_busy", S_MB, 1); push("coll_cnt", S_MCNT, 1); push("coll_data", S_MD, 32'h0000_0099);
        drain();
        mread(0, 3); mread(1, 9); mresv(3); mwrite(1, 9, 32'h0000_1999);
        push("swap_x3_now", S_MB, 0); push("swap_x9_now", S_MB + 1, 0);
        push("swap_x9_data_now", S_MD + 1, 32'h0000_1999);
        drain();
        tick();
        push("swap_x3_busy", S_MB, 1); push("swap_x9_busy", S_MB + 1, 0);
        push("swap_cnt", S_MCNT, 1); push("swap_any", S_MANY, 1);
        drain();
        mwrite(1, 3, 32'h0000_0033);
        tick();
        push("clr_x3_cnt", S_MCNT, 0); push("clr_x3_any", S_MANY, 0);
        drain();

        e_raddr = 5'd20; ewrite(0, 20, 32'h55); e_rv = 1'b1; e_ra = 5'd20;
        push("e20_data_now", S_ED, 0); push("e20_busy_now", S_EB, 0);
        drain();
        tick();
        push("e20_data", S_ED, 0); push("e20_busy", S_EB, 0);
        push("e20_cnt", S_ECNT, 0); push("e20_any", S_EANY, 0);
        drain();
        e_raddr = 5'd4;
        push("e4_alias", S_ED, 0);
        drain();
        e_raddr = 5'd15; ewrite(1, 15, 32'h55); e_rv = 1'b1; e_ra = 5'd15;
        push("e15_byp_now", S_ED, 32'h55);
        drain();
        tick();
        push("e15_data", S_ED, 32'h55); push("e15_busy", S_EB, 1); push("e15_cnt", S_ECNT, 1);
        drain();

        for (int i = 1; i < 32; i++) begin
            mresv(5'(i));
            tick();
            push($sformatf("fill_cnt_%0d", i), S_MCNT, 32'(i));
            drain();
        end
        push("fill_any", S_MANY, 1);
        drain();
        for (int i = 1; i < 32; i++) begin
            mwrite(1, 5'(i), 32'(i));
            tick();
            push($sformatf("drain_cnt_%0d", i), S_MCNT, 32'(31 - i));
            drain();
        end
        mread(0, 31);
        push("drain_any", S_MANY, 0); push("x31_data", S_MD, 32'd31); push("x31_busy", S_MB, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
